// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COLLECT  = 2'b01,
        ST_DISPENSE = 2'b10,
        ST_CHANGE   = 2'b11
    } state_e;

    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_10  = 2'b11;
    localparam logic [1:0] UNITS_5  = 2'd1;
    localparam logic [1:0] UNITS_10 = 2'd2;

    // Credit units carried by a coin code; zero means no coin.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  return UNITS_5;
            COIN_10: return UNITS_10;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_if.sv
// Coin, select and dispenser handshake bundle around the vending controller.
interface vend_if #(
    parameter int unsigned CREDIT_W = 4
);
    logic [1:0]          d_in;
    logic                sel;
    logic                cancel;
    logic                disp_req;
    logic                disp_ack;
    logic                chg_req;
    logic                chg_val;
    logic                chg_ack;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output d_in, sel, cancel, disp_ack, chg_ack,
        input  disp_req, chg_req, chg_val, coin_reject, credit, busy
    );

    modport slave (
        input  d_in, sel, cancel, disp_ack, chg_ack,
        output disp_req, chg_req, chg_val, coin_reject, credit, busy
    );
endinterface

// File: rtl/vend_timeout_cnt.sv
// Idle counter for the collect phase; flags the last cycle before auto-refund.
module vend_timeout_cnt #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TMR_W   = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c
);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_c = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: owns credit and decides vend, refund and change.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 3,
    parameter int unsigned MAX_CREDIT = 8,
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned TMR_W      = 10
) (
    input  logic   clk,
    input  logic   rst,
    vend_if.slave  bus
);
    localparam int unsigned SUM_W = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_req_q, disp_req_d;
    logic                chg_req_q, chg_req_d;
    logic                chg_val_q, chg_val_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [1:0]          units_c;
    logic                coin_vld_c;
    logic [SUM_W-1:0]    sum_c;
    logic                coin_fits_c;
    logic                tmr_clear_c;
    logic                expire_c;

    vend_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmr_clear_c),
        .enable_i (state_q == ST_COLLECT),
        .expire_c (expire_c)
    );

    // Coin decode and headroom check; the extra sum bit keeps the compare exact.
    always_comb begin
        units_c     = coin_units(bus.d_in);
        coin_vld_c  = (units_c != 2'd0);
        sum_c       = {1'b0, credit_q} + SUM_W'(units_c);
        coin_fits_c = (sum_c <= SUM_W'(MAX_CREDIT));
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_req_d    = disp_req_q;
        chg_req_d     = chg_req_q;
        coin_reject_d = 1'b0;
        tmr_clear_c   = (state_q != ST_COLLECT);

        case (state_q)
            ST_IDLE: begin
                if (coin_vld_c) begin
                    if (coin_fits_c) begin
                        credit_d = sum_c[CREDIT_W-1:0];
                        state_d  = ST_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            // Priority: cancel, then a sel that can pay, then the coin, then timeout.
            ST_COLLECT: begin
                if (bus.cancel) begin
                    coin_reject_d = coin_vld_c;
                    state_d       = ST_CHANGE;
                    chg_req_d     = (credit_q != '0);
                end else if (bus.sel && (credit_q >= CREDIT_W'(PRICE))) begin
                    coin_reject_d = coin_vld_c;
                    credit_d      = credit_q - CREDIT_W'(PRICE);
                    disp_req_d    = 1'b1;
                    state_d       = ST_DISPENSE;
                end else if (coin_vld_c && coin_fits_c) begin
                    credit_d    = sum_c[CREDIT_W-1:0];
                    tmr_clear_c = 1'b1;
                end else begin
                    coin_reject_d = coin_vld_c;
                    if (expire_c) begin
                        state_d   = ST_CHANGE;
                        chg_req_d = (credit_q != '0);
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_vld_c;
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d   = ST_CHANGE;
                        chg_req_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            // Each acked coin forces a one-cycle gap before the next request.
            ST_CHANGE: begin
                coin_reject_d = coin_vld_c;
                if (chg_req_q) begin
                    if (bus.chg_ack) begin
                        chg_req_d = 1'b0;
                        credit_d  = credit_q - (chg_val_q ? CREDIT_W'(2) : CREDIT_W'(1));
                        if (credit_d == '0) state_d = ST_IDLE;
                    end
                end else if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    chg_req_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        chg_val_d = chg_req_d && (credit_d >= CREDIT_W'(2));
        busy_d    = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            chg_val_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_req_q    <= disp_req_d;
            chg_req_q     <= chg_req_d;
            chg_val_q     <= chg_val_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.disp_req    = disp_req_q;
    assign bus.chg_req     = chg_req_q;
    assign bus.chg_val     = chg_val_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed and randomized bench for vend_ctrl against a behavioural vending model.
module tb_vend_ctrl;
    localparam int unsigned PRICE      = 3;
    localparam int unsigned MAX_CREDIT = 8;
    localparam int unsigned CREDIT_W   = 4;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned TMR_W      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vend_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_ctrl #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W),
        .TIMEOUT    (TIMEOUT),
        .TMR_W      (TMR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_fail  = 0;

    // Behavioural model: what the machine is doing, the money it holds, and
    // the requests it should be showing.
    typedef enum {M_WAIT, M_PAYING, M_VENDING, M_REFUNDING} mode_e;
    mode_e m_mode    = M_WAIT;
    int    m_credit  = 0;
    int    m_idle    = 0;
    bit    m_disp    = 0;
    bit    m_chg     = 0;
    bit    m_chgv    = 0;
    bit    m_rej     = 0;
    bit    m_busy    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_refund();
        m_mode = M_REFUNDING;
        m_chg  = (m_credit > 0);
    endtask

    task automatic model_step(input logic [1:0] d, input bit s, input bit c,
                              input bit da, input bit ca, input bit r);
        int u;
        u     = (d == 2'b10) ? 1 : (d == 2'b11) ? 2 : 0;
        m_rej = 0;
        if (r) begin
            m_mode = M_WAIT; m_credit = 0; m_idle = 0; m_disp = 0; m_chg = 0;
        end else begin
            case (m_mode)
                M_WAIT: begin
                    if (u > 0 && m_credit + u <= MAX_CREDIT) begin
                        m_credit += u; m_mode = M_PAYING; m_idle = 0;
                    end else if (u > 0) m_rej = 1;
                end
                M_PAYING: begin
                    if (c) begin
                        m_rej = (u > 0); start_refund();
                    end else if (s && m_credit >= PRICE) begin
                        m_rej = (u > 0); m_credit -= PRICE; m_disp = 1; m_mode = M_VENDING;
                    end else if (u > 0 && m_credit + u <= MAX_CREDIT) begin
                        m_credit += u; m_idle = 0;
                    end else begin
                        m_rej = (u > 0);
                        if (m_idle == TIMEOUT - 1) start_refund();
                        else m_idle++;
                    end
                end
                M_VENDING: begin
                    m_rej = (u > 0);
                    if (da) begin
                        m_disp = 0;
                        if (m_credit > 0) start_refund(); else m_mode = M_WAIT;
                    end
                end
                M_REFUNDING: begin
                    m_rej = (u > 0);
                    if (m_chg) begin
                        if (ca) begin
                            m_credit -= m_chgv ? 2 : 1;
                            m_chg = 0;
                            if (m_credit == 0) m_mode = M_WAIT;
                        end
                    end else if (m_credit == 0) m_mode = M_WAIT;
                    else m_chg = 1;
                end
                default: m_mode = M_WAIT;
            endcase
            if (m_mode != M_PAYING) m_idle = 0;
        end
        m_chgv = m_chg && (m_credit >= 2);
        m_busy = (m_mode == M_VENDING) || (m_mode == M_REFUNDING);
    endtask

    task automatic check_model();
        chk("disp_req",    32'(bus.disp_req),    32'(m_disp));
        chk("chg_req",     32'(bus.chg_req),     32'(m_chg));
        chk("chg_val",     32'(bus.chg_val),     32'(m_chgv));
        chk("coin_reject", 32'(bus.coin_reject), 32'(m_rej));
        chk("credit",      32'(bus.credit),      32'(m_credit));
        chk("busy",        32'(bus.busy),        32'(m_busy));
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after it.
    task automatic step(input logic [1:0] d, input bit s, input bit c,
                        input bit da, input bit ca, input bit r);
        bus.d_in = d; bus.sel = s; bus.cancel = c;
        bus.disp_ack = da; bus.chg_ack = ca; rst = r;
        @(posedge clk);
        model_step(d, s, c, da, ca, r);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && bus.busy; i++) begin
            if (bus.disp_req || bus.chg_req) step(2'b00, 0, 0, 1, 1, 0);
            else                             idle(1);
        end
        chk("drain_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int quiet;
        logic [1:0] d;
        bus.d_in = 2'b00; bus.sel = 0; bus.cancel = 0; bus.disp_ack = 0; bus.chg_ack = 0;

        // Reset
        step(2'b00, 0, 0, 0, 0, 1);
        step(2'b11, 1, 1, 1, 1, 1);
        chk("rst_disp", 32'(bus.disp_req), 32'd0);
        chk("rst_chg", 32'(bus.chg_req), 32'd0);
        chk("rst_credit", 32'(bus.credit), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        idle(2);

        // Exact payment
        step(2'b11, 0, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0, 0);
        chk("exact_credit3", 32'(bus.credit), 32'd3);
        step(2'b00, 1, 0, 0, 0, 0);
        chk("exact_disp", 32'(bus.disp_req), 32'd1);
        chk("exact_credit0", 32'(bus.credit), 32'd0);
        idle(3);
        chk("exact_hold", 32'(bus.disp_req), 32'd1);
        step(2'b00, 0, 0, 1, 0, 0);
        chk("exact_done", 32'(bus.disp_req), 32'd0);
        chk("exact_nochg", 32'(bus.chg_req), 32'd0);
        chk("exact_idle", 32'(bus.busy), 32'd0);
        idle(2);

        // Overpay with change
        repeat (3) step(2'b11, 0, 0, 0, 0, 0);
        step(2'b00, 1, 0, 0, 0, 0);
        chk("over_credit3", 32'(bus.credit), 32'd3);
        step(2'b00, 0, 0, 1, 0, 0);
        chk("over_chg1", 32'(bus.chg_req), 32'd1);
        chk("over_val1", 32'(bus.chg_val), 32'd1);
        step(2'b00, 0, 0, 0, 1, 0);
        chk("over_credit1", 32'(bus.credit), 32'd1);
        chk("over_gap", 32'(bus.chg_req), 32'd0);
        idle(1);
        chk("over_chg2", 32'(bus.chg_req), 32'd1);
        chk("over_val0", 32'(bus.chg_val), 32'd0);
        step(2'b00, 0, 0, 0, 1, 0);
        chk("over_credit0", 32'(bus.credit), 32'd0);
        chk("over_idle", 32'(bus.busy), 32'd0);

        // Credit limit and coin during dispense
        repeat (4) step(2'b11, 0, 0, 0, 0, 0);
        chk("lim_credit8", 32'(bus.credit), 32'd8);
        step(2'b11, 0, 0, 0, 0, 0);
        chk("lim_reject", 32'(bus.coin_reject), 32'd1);
        chk("lim_hold8", 32'(bus.credit), 32'd8);
        idle(1);
        chk("lim_pulse", 32'(bus.coin_reject), 32'd0);
        step(2'b00, 1, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0, 0);
        chk("disp_coin_rej", 32'(bus.coin_reject), 32'd1);
        drain();

        // Cancel with 2 units
        step(2'b11, 0, 0, 0, 0, 0);
        step(2'b00, 0, 1, 0, 0, 0);
        chk("cancel_chg", 32'(bus.chg_req), 32'd1);
        chk("cancel_val", 32'(bus.chg_val), 32'd1);
        step(2'b00, 0, 0, 0, 1, 0);
        chk("cancel_idle", 32'(bus.busy), 32'd0);

        // Timeout with 1 unit
        step(2'b10, 0, 0, 0, 0, 0);
        idle(TIMEOUT - 1);
        chk("tmo_early", 32'(bus.chg_req), 32'd0);
        idle(1);
        chk("tmo_chg", 32'(bus.chg_req), 32'd1);
        chk("tmo_val", 32'(bus.chg_val), 32'd0);
        drain();

        // Simultaneous events in the paying phase
        step(2'b11, 0, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0, 0);
        step(2'b10, 1, 0, 0, 0, 0);
        chk("selcoin_disp", 32'(bus.disp_req), 32'd1);
        chk("selcoin_rej", 32'(bus.coin_reject), 32'd1);
        drain();
        step(2'b11, 0, 0, 0, 0, 0);
        step(2'b10, 0, 0, 0, 0, 0);
        step(2'b00, 1, 1, 0, 0, 0);
        chk("selcan_nodisp", 32'(bus.disp_req), 32'd0);
        chk("selcan_chg", 32'(bus.chg_req), 32'd1);
        drain();
        step(2'b10, 0, 0, 0, 0, 0);
        step(2'b10, 1, 0, 0, 0, 0);
        chk("poorsel_credit2", 32'(bus.credit), 32'd2);
        chk("poorsel_nodisp", 32'(bus.disp_req), 32'd0);
        step(2'b00, 0, 1, 0, 0, 0);
        drain();

        // Reset mid-change, then a stale ack
        step(2'b11, 0, 0, 0, 0, 0);
        step(2'b00, 0, 1, 0, 0, 0);
        step(2'b00, 0, 0, 0, 0, 1);
        chk("rstmid_chg", 32'(bus.chg_req), 32'd0);
        chk("rstmid_credit", 32'(bus.credit), 32'd0);
        step(2'b00, 0, 0, 0, 1, 0);
        chk("stale_ack", 32'(bus.busy), 32'd0);

        // Randomized traffic against the model
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = 20;
            if (quiet > 0) begin
                quiet--;
                step(2'b00, 0, 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 0);
            end else begin
                d = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(2, 3))
                                                : 2'($urandom_range(0, 1));
                step(d, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 499) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
